param_data_buffer: RTL and testbench

Parametrised FIFO data buffer that replaces the fixed 64x8 register-file buffer and its externally driven pointers. Read/write pointers, occupancy and full/empty status are held internally. Provides simultaneous read and write in one cycle, flush, registered read data with a valid strobe, and overflow/underflow error pulses. Sits between the packet/protocol front end (writer) and the data consumer (reader) in the data path.

---
 rtl/buffer_pkg.sv | 15 +
 rtl/buffer_storage_array.sv | 38 +++
 rtl/param_data_buffer.sv | 132 +++++++++++++
 tb/tb_param_data_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared definitions for the parametrised data buffer: request encoding and default sizing.
package buffer_pkg;

    localparam int BUF_DATA_WIDTH = 8;
    localparam int BUF_DEPTH      = 64;

    // Encoded as {write_enable, read_enable} so the request pair can be cast directly.
    typedef enum logic [1:0] {
        BUF_NOP   = 2'b00,
        BUF_READ  = 2'b01,
        BUF_WRITE = 2'b10,
        BUF_RW    = 2'b11
    } buf_op_t;

endpackage

// File: rtl/buffer_storage_array.sv
// Storage for the data buffer: one write port and one registered read port.
// The array itself is never reset; only the read-data register is.
module buffer_storage_array #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Entry write; a same-cycle read of the same slot still sees the old entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read data, held when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: rtl/param_data_buffer.sv
// Parametrised FIFO buffer between the protocol front end and the data consumer.
// Occupancy is the single source of full/empty; pointers are never compared.
module param_data_buffer
    import buffer_pkg::*;
#(
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int DEPTH      = BUF_DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic [ADDR_W:0]       occupancy,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   OCC_ZERO = '0;
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   occupancy_r;
    logic              read_valid_r;
    logic              overflow_r;
    logic              underflow_r;

    buf_op_t           op_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              ovf_s;
    logic              udf_s;

    assign op_s = buf_op_t'({write_enable, read_enable});

    // Accept decisions; flush silently swallows same-cycle requests.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        ovf_s    = 1'b0;
        udf_s    = 1'b0;
        if (flush) begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end else begin
            case (op_s)
                BUF_NOP: begin
                    wr_acc_s = 1'b0;
                end
                BUF_WRITE: begin
                    wr_acc_s = !full;
                    ovf_s    = full;
                end
                BUF_READ: begin
                    rd_acc_s = !empty;
                    udf_s    = empty;
                end
                BUF_RW: begin
                    // A popped slot frees room, so a full buffer still takes the write.
                    rd_acc_s = !empty;
                    udf_s    = empty;
                    wr_acc_s = 1'b1;
                end
                default: begin
                    wr_acc_s = 1'b0;
                    rd_acc_s = 1'b0;
                end
            endcase
        end
    end

    // Pointers, occupancy and status pulses.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            occupancy_r  <= OCC_ZERO;
            read_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   occupancy_r <= occupancy_r + (ADDR_W+1)'(1);
                2'b01:   occupancy_r <= occupancy_r - (ADDR_W+1)'(1);
                default: occupancy_r <= occupancy_r;
            endcase
            read_valid_r <= rd_acc_s;
            overflow_r   <= ovf_s;
            underflow_r  <= udf_s;
        end
    end

    buffer_storage_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (write_data),
        .re    (rd_acc_s),
        .raddr (rd_ptr_r),
        .rdata (read_data)
    );

    assign occupancy  = occupancy_r;
    assign read_valid = read_valid_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;
    assign empty      = (occupancy_r == OCC_ZERO);
    assign full       = (occupancy_r == OCC_FULL);

endmodule

// File: tb/tb_param_data_buffer.sv
// Bench for param_data_buffer: an 8x64 and a 16x8 instance, each checked every cycle
// against a circular-array FIFO model, with directed scenarios followed by random traffic.
module tb_param_data_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  rst_v, flush_v, we_v, re_v;
    logic [15:0] wd_v [2];

    logic [7:0]  a_rd;  logic [6:0] a_occ;
    logic [15:0] b_rd;  logic [3:0] b_occ;
    logic [1:0]  rv_v, emp_v, ful_v, ovf_v, udf_v;

    param_data_buffer #(.DATA_WIDTH(8), .DEPTH(64)) dut_a (
        .clk(clk), .rst(rst_v[0]), .flush(flush_v[0]),
        .write_enable(we_v[0]), .write_data(wd_v[0][7:0]), .read_enable(re_v[0]),
        .read_data(a_rd), .read_valid(rv_v[0]), .occupancy(a_occ),
        .empty(emp_v[0]), .full(ful_v[0]), .overflow(ovf_v[0]), .underflow(udf_v[0]));

    param_data_buffer #(.DATA_WIDTH(16), .DEPTH(8)) dut_b (
        .clk(clk), .rst(rst_v[1]), .flush(flush_v[1]),
        .write_enable(we_v[1]), .write_data(wd_v[1]), .read_enable(re_v[1]),
        .read_data(b_rd), .read_valid(rv_v[1]), .occupancy(b_occ),
        .empty(emp_v[1]), .full(ful_v[1]), .overflow(ovf_v[1]), .underflow(udf_v[1]));

    // Reference model: circular array with head index and count, per instance.
    int          m_depth [2] = '{64, 8};
    logic [15:0] m_mask  [2] = '{16'h00FF, 16'hFFFF};
    logic [15:0] m_mem   [2][64];
    int          m_head  [2];
    int          m_cnt   [2];
    logic [15:0] m_rdata [2];
    logic        m_valid [2];
    logic        m_ovf   [2];
    logic        m_udf   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] out_rd(input int id);
        return (id == 0) ? {8'h00, a_rd} : b_rd;
    endfunction

    function automatic int out_occ(input int id);
        return (id == 0) ? int'(a_occ) : int'(b_occ);
    endfunction

    // One clock on instance id: drive, advance the model, then compare every output.
    task automatic cyc(input int id, input bit r, input bit f, input bit w,
                       input logic [15:0] d, input bit rd);
        bit rd_ok, wr_ok;
        rst_v = 2'b00; flush_v = 2'b00; we_v = 2'b00; re_v = 2'b00;
        rst_v[id] = r; flush_v[id] = f; we_v[id] = w; re_v[id] = rd; wd_v[id] = d;
        if (r || f) begin
            m_head[id] = 0; m_cnt[id] = 0;
            m_valid[id] = 1'b0; m_ovf[id] = 1'b0; m_udf[id] = 1'b0;
            if (r) m_rdata[id] = 16'h0000;
        end else begin
            rd_ok = rd && (m_cnt[id] > 0);
            wr_ok = w && ((m_cnt[id] < m_depth[id]) || rd_ok);
            m_ovf[id]   = w && !wr_ok;
            m_udf[id]   = rd && !rd_ok;
            m_valid[id] = rd_ok;
            if (rd_ok) begin
                m_rdata[id] = m_mem[id][m_head[id]];
                m_head[id]  = (m_head[id] + 1) % m_depth[id];
                m_cnt[id]--;
            end
            if (wr_ok) begin
                m_mem[id][(m_head[id] + m_cnt[id]) % m_depth[id]] = d & m_mask[id];
                m_cnt[id]++;
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("i%0d read_valid", id), 32'(rv_v[id]), 32'(m_valid[id]));
        check($sformatf("i%0d read_data", id),  32'(out_rd(id)), 32'(m_rdata[id]));
        check($sformatf("i%0d occupancy", id),  32'(out_occ(id)), 32'(m_cnt[id]));
        check($sformatf("i%0d empty", id),      32'(emp_v[id]), 32'(m_cnt[id] == 0));
        check($sformatf("i%0d full", id),       32'(ful_v[id]), 32'(m_cnt[id] == m_depth[id]));
        check($sformatf("i%0d overflow", id),   32'(ovf_v[id]), 32'(m_ovf[id]));
        check($sformatf("i%0d underflow", id),  32'(udf_v[id]), 32'(m_udf[id]));
        we_v[id] = 1'b0; re_v[id] = 1'b0; flush_v[id] = 1'b0; rst_v[id] = 1'b0;
    endtask

    task automatic fill_drain_wrap(input int id);
        int d = m_depth[id];
        for (int i = 0; i < d; i++) cyc(id, 0, 0, 1, 16'(i), 0);
        cyc(id, 0, 0, 1, 16'h00AA, 0);
        check($sformatf("i%0d ovf_pulse", id), 32'(ovf_v[id]), 32'd1);
        cyc(id, 0, 0, 0, 16'h0000, 0);
        check($sformatf("i%0d ovf_once", id), 32'(ovf_v[id]), 32'd0);
        cyc(id, 0, 0, 1, 16'h00BB, 1);
        check($sformatf("i%0d rw_full_data", id), 32'(out_rd(id)), 32'h0);
        check($sformatf("i%0d rw_full_occ", id), 32'(out_occ(id)), 32'(d));
        for (int i = 1; i < d; i++) cyc(id, 0, 0, 0, 16'h0000, 1);
        check($sformatf("i%0d drain_last", id), 32'(out_rd(id)), 32'(d - 1));
        cyc(id, 0, 0, 0, 16'h0000, 1);
        check($sformatf("i%0d wrap_bb", id), 32'(out_rd(id)), 32'h00BB);
        cyc(id, 0, 0, 0, 16'h0000, 1);
        check($sformatf("i%0d udf_empty", id), 32'(udf_v[id]), 32'd1);
    endtask

    task automatic random_traffic(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            int p = int'($urandom_range(0, 99));
            cyc(id, p == 0, (p >= 1) && (p <= 2), $urandom_range(0, 99) < 55,
                16'($urandom), $urandom_range(0, 99) < 45);
        end
    endtask

    initial begin
        rst_v = 2'b11; flush_v = 2'b00; we_v = 2'b00; re_v = 2'b00;
        wd_v[0] = 16'h0; wd_v[1] = 16'h0;
        for (int k = 0; k < 2; k++) begin
            m_head[k] = 0; m_cnt[k] = 0; m_rdata[k] = 16'h0;
            m_valid[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
        end
        @(posedge clk); #1;
        cyc(0, 1, 0, 0, 16'h0, 0);
        cyc(1, 1, 0, 0, 16'h0, 0);

        // Basic ordering on the 8x64 instance.
        cyc(0, 0, 0, 1, 16'h0011, 0);
        cyc(0, 0, 0, 1, 16'h0022, 0);
        cyc(0, 0, 0, 1, 16'h0033, 0);
        check("occ_three", 32'(a_occ), 32'd3);
        cyc(0, 0, 0, 0, 16'h0, 1);
        check("first_pop", 32'(a_rd), 32'h11);
        cyc(0, 0, 0, 0, 16'h0, 1);
        cyc(0, 0, 0, 0, 16'h0, 1);
        check("third_pop", 32'(a_rd), 32'h33);

        fill_drain_wrap(0);

        // Read+write on empty: write lands, read rejected.
        cyc(0, 0, 0, 1, 16'h005C, 1);
        check("rw_empty_udf", 32'(udf_v[0]), 32'd1);
        check("rw_empty_valid", 32'(rv_v[0]), 32'd0);
        cyc(0, 0, 0, 0, 16'h0, 1);
        check("rw_empty_pop", 32'(a_rd), 32'h5C);

        // Flush with concurrent requests.
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 16'(8'hA0 + i), 0);
        cyc(0, 0, 1, 1, 16'h00EE, 1);
        check("flush_hold", 32'(a_rd), 32'h5C);
        cyc(0, 0, 0, 1, 16'h0077, 0);
        cyc(0, 0, 0, 0, 16'h0, 1);
        check("post_flush", 32'(a_rd), 32'h77);

        // Reset wins over flush and write mid-traffic.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 16'(8'h40 + i), i > 2);
        cyc(0, 1, 1, 1, 16'h0099, 1);
        check("rst_rdata", 32'(a_rd), 32'h0);
        check("rst_occ", 32'(a_occ), 32'd0);

        fill_drain_wrap(1);

        random_traffic(0, 3000);
        random_traffic(1, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
